// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and data memory.
//   master (MEM stage): drives Dm_req/Dm_we/Dm_addr/Dm_be/Dm_wdata, receives Dm_ack/Dm_rdata
//   slave  (memory)   : the mirror image
// Dm_addr is a word address (byte address [31:2]).
// Dm_ack is a one-cycle strobe, and Dm_rdata is valid with it.
interface mem_access_stage_if;
  logic        Dm_req;
  logic        Dm_we;
  logic [29:0] Dm_addr;
  logic [3:0]  Dm_be;
  logic [31:0] Dm_wdata;
  logic        Dm_ack;
  logic [31:0] Dm_rdata;

  modport master (
    output Dm_req, Dm_we, Dm_addr, Dm_be, Dm_wdata,
    input  Dm_ack, Dm_rdata
  );

  modport slave (
    input  Dm_req, Dm_we, Dm_addr, Dm_be, Dm_wdata,
    output Dm_ack, Dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit.
// It runs one req/ack bus transaction per load or store that sits in MEM.
// It lane-aligns store data and sign- or zero-extends load data.
// Mem_Stall freezes the upstream pipeline and Mem_Wr while a transaction is in flight.
//
// Ports:
//   Clk, Rst_n          clock (rising edge) and asynchronous active-low reset
//   Mem_alu_result      effective byte address
//   Mem_busB            store data
//   Mem_MemRead/Write   access type; a store wins when both are high
//   Mem_MemSize         00 byte, 01 half, 10/11 word
//   Mem_MemSign         1 = sign-extend the load
//   Mem_dout            formatted load data, held between loads
//   Mem_Stall           combinational pipeline freeze
//   Mem_BusErr          one-cycle pulse when the bus times out
//   Mem_AddrErr         misaligned access (only with MISALIGN_TRAP_EN)
//   dm                  data-memory bus (mem_access_stage_if.master)
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// When it is undefined, the low address bits are simply ignored for half and word accesses.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [31:0]              Mem_alu_result,
  input  logic [31:0]              Mem_busB,
  input  logic                     Mem_MemRead,
  input  logic                     Mem_MemWrite,
  input  logic [1:0]               Mem_MemSize,
  input  logic                     Mem_MemSign,
  output logic [31:0]              Mem_dout,
  output logic                     Mem_Stall,
  output logic                     Mem_BusErr,
  output logic                     Mem_AddrErr,
  mem_access_stage_if.master       dm
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q, we_q, buserr_q;
  logic [29:0]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, dout_q;
  // Load-format context captured at issue; it is used when the ack arrives.
  logic              ld_q, sign_q;
  logic [1:0]        lo_q, size_q;

  logic access, misalign, stall, issue, fin_ack, fin_to;

  assign access = Mem_MemRead | Mem_MemWrite;

`ifdef MISALIGN_TRAP_EN
  assign misalign = access &
                    (((Mem_MemSize == 2'b01) & Mem_alu_result[0]) |
                     (Mem_MemSize[1] & (Mem_alu_result[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign Mem_AddrErr = misalign;

  // ---------------- store lane formatting ----------------
  logic [3:0][7:0] bb, st_wd;
  logic [3:0]      st_be;
  assign bb = Mem_busB;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign st_wd[g] = (Mem_MemSize == 2'b00) ? bb[0]   :
                      (Mem_MemSize == 2'b01) ? bb[g%2] : bb[g];
  end

  always_comb begin
    st_be = 4'b1111;
    if (Mem_MemWrite) begin
      unique case (Mem_MemSize)
        2'b00:   st_be = 4'b0001 << Mem_alu_result[1:0];
        2'b01:   st_be = Mem_alu_result[1] ? 4'b1100 : 4'b0011;
        default: st_be = 4'b1111;
      endcase
    end
  end

  // ---------------- load formatting ----------------
  logic [3:0][7:0] rb;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_fmt;
  assign rb   = dm.Dm_rdata;
  assign ld_b = rb[lo_q];
  assign ld_h = lo_q[1] ? {rb[3], rb[2]} : {rb[1], rb[0]};

  always_comb begin
    unique case (size_q)
      2'b00:   ld_fmt = {{24{sign_q & ld_b[7]}}, ld_b};
      2'b01:   ld_fmt = {{16{sign_q & ld_h[15]}}, ld_h};
      default: ld_fmt = dm.Dm_rdata;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    issue   = 1'b0;
    fin_ack = 1'b0;
    fin_to  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access && !misalign) begin
          stall   = 1'b1;
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // The ack takes priority over a timeout in the same cycle.
        if (dm.Dm_ack) begin
          fin_ack = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fin_to  = 1'b1;
          state_d = S_DONE;
        end
      end
      // The inputs still show the finished instruction, so the FSM must not reissue.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gate the stall with reset so the pipeline is released as soon as reset asserts,
  // even though the inputs still show an access.
  assign Mem_Stall = stall & Rst_n;

  // ---------------- datapath ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      buserr_q <= 1'b0;
      ld_q     <= 1'b0;
      sign_q   <= 1'b0;
      lo_q     <= '0;
      size_q   <= '0;
    end else begin
      buserr_q <= fin_to;
      if (issue) begin
        cnt_q   <= '0;
        req_q   <= 1'b1;
        we_q    <= Mem_MemWrite;
        addr_q  <= Mem_alu_result[31:2];
        be_q    <= st_be;
        wdata_q <= Mem_MemWrite ? st_wd : 32'h0;
        ld_q    <= ~Mem_MemWrite;
        sign_q  <= Mem_MemSign;
        lo_q    <= Mem_alu_result[1:0];
        size_q  <= Mem_MemSize;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fin_ack) begin
        req_q <= 1'b0;
        if (ld_q) dout_q <= ld_fmt;
      end
      if (fin_to) begin
        req_q <= 1'b0;
        if (ld_q) dout_q <= 32'h0;
      end
    end
  end

  assign Mem_dout    = dout_q;
  assign Mem_BusErr  = buserr_q;
  assign dm.Dm_req   = req_q;
  assign dm.Dm_we    = we_q;
  assign dm.Dm_addr  = addr_q;
  assign dm.Dm_be    = be_q;
  assign dm.Dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int TO = 6;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        Clk, Rst_n;
  logic [31:0] Mem_alu_result, Mem_busB, Mem_dout;
  logic        Mem_MemRead, Mem_MemWrite, Mem_MemSign;
  logic [1:0]  Mem_MemSize;
  logic        Mem_Stall, Mem_BusErr, Mem_AddrErr;

  mem_access_stage_if dm_if ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Mem_alu_result(Mem_alu_result), .Mem_busB(Mem_busB),
    .Mem_MemRead(Mem_MemRead), .Mem_MemWrite(Mem_MemWrite),
    .Mem_MemSize(Mem_MemSize), .Mem_MemSign(Mem_MemSign),
    .Mem_dout(Mem_dout), .Mem_Stall(Mem_Stall),
    .Mem_BusErr(Mem_BusErr), .Mem_AddrErr(Mem_AddrErr),
    .dm(dm_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          nchk = 0, nerr = 0;
  logic [31:0] exp_dout = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
    return TRAP_EN && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0));
  endfunction

  // Reference load result: shift the selected lane down, mask it, then extend it.
  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] rd);
    int          ofs;
    logic [31:0] mask, v;
    if (sz == 2'd0)      begin ofs = int'(a[1:0]);           mask = 32'hFF;   end
    else if (sz == 2'd1) begin ofs = (int'(a[1:0]) / 2) * 2; mask = 32'hFFFF; end
    else                 begin ofs = 0;                      mask = 32'hFFFF_FFFF; end
    v = (rd >> (8 * ofs)) & mask;
    if (sg && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  task automatic set_idle();
    Mem_MemRead = 1'b0; Mem_MemWrite = 1'b0;
  endtask

  // delay = WAIT cycle (1-based) in which the ack is given; 0 means no ack.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] rdata, input int delay);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          ewait, stall;
    bit          trap, is_ld, ok, done;
    @(negedge Clk);
    Mem_MemRead = rd; Mem_MemWrite = wr; Mem_MemSize = sz; Mem_MemSign = sg;
    Mem_alu_result = a; Mem_busB = b; dm_if.Dm_ack = 1'b0;
    trap  = misal(sz, a);
    is_ld = rd && !wr;
    #1;
    chk("addr_err", 32'(Mem_AddrErr), 32'(trap));
    chk("stall_idle", 32'(Mem_Stall), 32'(!trap));
    if (trap) begin
      @(negedge Clk);
      chk("trap_req", 32'(dm_if.Dm_req), 32'd0);
      chk("trap_stall", 32'(Mem_Stall), 32'd0);
      chk("trap_dout", Mem_dout, exp_dout);
      @(posedge Clk); #1 set_idle();
      return;
    end
    if (!wr)             ebe = 4'hF;
    else if (sz == 2'd0) ebe = 4'd1 << a[1:0];
    else if (sz == 2'd1) ebe = 4'd3 << (a[1:0] & 2'b10);
    else                 ebe = 4'hF;
    if (sz == 2'd0)      ewd = {24'd0, b[7:0]} * 32'h0101_0101;
    else if (sz == 2'd1) ewd = {16'd0, b[15:0]} * 32'h0001_0001;
    else                 ewd = b;
    ok    = (delay >= 1) && (delay <= TO);
    ewait = ok ? delay : TO;
    stall = 1;
    done  = 1'b0;
    for (int k = 1; k <= TO + 4 && !done; k++) begin
      @(negedge Clk);
      dm_if.Dm_ack = 1'b0; dm_if.Dm_rdata = $urandom;
      if (!Mem_Stall) done = 1'b1;
      else begin
        stall++;
        chk("wait_req", 32'(dm_if.Dm_req), 32'd1);
        chk("wait_we", 32'(dm_if.Dm_we), 32'(wr));
        chk("wait_addr", 32'(dm_if.Dm_addr), 32'(a[31:2]));
        chk("wait_be", 32'(dm_if.Dm_be), 32'(ebe));
        if (wr) chk("wait_wdata", dm_if.Dm_wdata, ewd);
        if (k == delay) begin dm_if.Dm_ack = 1'b1; dm_if.Dm_rdata = rdata; end
      end
    end
    chk("done_in_bound", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stall), 32'(1 + ewait));
    chk("done_req", 32'(dm_if.Dm_req), 32'd0);
    chk("bus_err", 32'(Mem_BusErr), 32'(!ok));
    if (is_ld) exp_dout = ok ? ld_model(sz, sg, a, rdata) : 32'h0;
    chk("dout", Mem_dout, exp_dout);
    @(posedge Clk); #1 set_idle();
    @(negedge Clk);
    chk("bus_err_pulse", 32'(Mem_BusErr), 32'd0);
    chk("idle_stall", 32'(Mem_Stall), 32'd0);
    chk("idle_req", 32'(dm_if.Dm_req), 32'd0);
    chk("idle_dout", Mem_dout, exp_dout);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, dly, op;
    Rst_n = 1'b0;
    Mem_alu_result = 32'h0; Mem_busB = 32'h0; Mem_MemSize = 2'd2; Mem_MemSign = 1'b0;
    Mem_MemRead = 1'b1; Mem_MemWrite = 1'b0;
    dm_if.Dm_ack = 1'b0; dm_if.Dm_rdata = 32'h0;
    #12;
    // Reset state; the stall must stay low even with a load on the inputs.
    chk("rst_req", 32'(dm_if.Dm_req), 32'd0);
    chk("rst_we", 32'(dm_if.Dm_we), 32'd0);
    chk("rst_addr", 32'(dm_if.Dm_addr), 32'd0);
    chk("rst_be", 32'(dm_if.Dm_be), 32'd0);
    chk("rst_wdata", dm_if.Dm_wdata, 32'd0);
    chk("rst_dout", Mem_dout, 32'd0);
    chk("rst_buserr", 32'(Mem_BusErr), 32'd0);
    chk("rst_stall", 32'(Mem_Stall), 32'd0);
    set_idle();
    @(negedge Clk); Rst_n = 1'b1;

    // Directed cases
    do_access(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1);
    do_access(0, 1, 2'd1, 0, 32'h0000_0042, 32'h0000_BEEF, 32'h0, 1);
    do_access(1, 0, 2'd1, 0, 32'h0000_0008, 32'h0, 32'h1234_ABCD, 5);
    do_access(1, 0, 2'd2, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    do_access(1, 0, 2'd2, 0, 32'h0000_0020, 32'h0, 32'h1111_2222, TO);
    do_access(1, 1, 2'd0, 0, 32'h0000_0031, 32'h0000_00A5, 32'hFFFF_FFFF, 2);
    do_access(1, 0, 2'd2, 0, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 1);

    // An ack while the FSM is idle must be ignored.
    @(negedge Clk); dm_if.Dm_ack = 1'b1; dm_if.Dm_rdata = 32'h5555_5555;
    @(negedge Clk); dm_if.Dm_ack = 1'b0;
    chk("stray_ack_req", 32'(dm_if.Dm_req), 32'd0);
    chk("stray_ack_stall", 32'(Mem_Stall), 32'd0);
    chk("stray_ack_dout", Mem_dout, exp_dout);

    // Reset asserted in the middle of WAIT
    @(negedge Clk);
    Mem_MemRead = 1'b1; Mem_MemWrite = 1'b0; Mem_MemSize = 2'd2; Mem_alu_result = 32'h40;
    @(negedge Clk);
    chk("mid_wait_req", 32'(dm_if.Dm_req), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dm_if.Dm_req), 32'd0);
    chk("mid_rst_stall", 32'(Mem_Stall), 32'd0);
    exp_dout = 32'h0;
    chk("mid_rst_dout", Mem_dout, exp_dout);
    set_idle();
    @(negedge Clk); Rst_n = 1'b1;
    do_access(1, 0, 2'd1, 1, 32'h0000_0082, 32'h0, 32'h9876_0001, 2);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      r  = $urandom_range(0, 9);
      dly = (r == 0) ? 0 : (r == 9) ? TO + 1 : ((r > TO) ? TO : r);
      do_access(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, dly);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit of the 5-stage pipeline. It sits between the Ex_Mem register and the Mem_Wr register. It takes the effective address and store data from Ex_Mem, runs a req/ack transaction on the data-memory bus, and byte-aligns and sign-extends load data. The result is presented as Mem_dout to Mem_Wr, and Mem_Stall freezes PC/IF_ID/ID_Ex/Ex_Mem/Mem_Wr while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for Dm_ack before abort (1..2^CNT_W-1)
CNT_W, 8, width of timeout counter

Ports:
Clk  input  1  pipeline clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Mem_alu_result  input  32  effective address from Ex_Mem
Mem_busB  input  32  store data from Ex_Mem
Mem_MemRead  input  1  load in MEM stage
Mem_MemWrite  input  1  store in MEM stage
Mem_MemSize  input  2  00 byte, 01 half, 10 word, 11 treated as word
Mem_MemSign  input  1  1 = sign-extend load, 0 = zero-extend
Mem_dout  output  32  formatted load data to Mem_Wr
Mem_Stall  output  1  freeze upstream stages and Mem_Wr
Mem_BusErr  output  1  one-cycle pulse: transaction timed out
Mem_AddrErr  output  1  misaligned access (see Optional Feature)
Dm_req  output  1  bus request, registered
Dm_we  output  1  1 = write
Dm_addr  output  30  word address [31:2]
Dm_be  output  4  byte enables
Dm_wdata  output  32  lane-replicated store data
Dm_ack  input  1  one-cycle completion strobe from memory
Dm_rdata  input  32  read word, valid with Dm_ack

Behaviour:
- Reset (async, Rst_n=0): state IDLE. Dm_req=0, Dm_we=0, Dm_addr=0, Dm_be=0, Dm_wdata=0, Mem_dout=0, Mem_BusErr=0, counter=0. Mem_Stall=0. Reset mid-transaction drops Dm_req immediately; memory must tolerate the abandoned request.
- access = Mem_MemRead | Mem_MemWrite. If both are high, the access is a store.
- FSM, three states:
  - IDLE: on access (and not trapped), Mem_Stall=1 combinationally. At the next edge, register Dm_req=1 and Dm_we/Dm_addr/Dm_be/Dm_wdata, clear counter, go to WAIT. With no access: Mem_Stall=0, stay in IDLE.
  - WAIT: Mem_Stall=1. Dm_* held stable, counter increments each cycle. On Dm_ack: Dm_req=0. For a load, Mem_dout <= formatted Dm_rdata; go to DONE. If counter reaches TIMEOUT_CYCLES-1 without ack: Dm_req=0, Mem_dout <= 0 for loads, Mem_BusErr=1 for one cycle, go to DONE.
  - DONE: Mem_Stall=0, so the pipeline advances and Mem_Wr captures Mem_dout. Unconditionally go to IDLE; no reissue although the inputs still show the same instruction.
- Minimum access latency: 3 cycles (IDLE, WAIT with ack in its first cycle, DONE). Each extra ack wait adds 1 cycle.
- Mem_dout holds its last value for non-load instructions and for stores.
- Store lanes, by addr[1:0]:
  - byte: Dm_wdata = {4{busB[7:0]}}, Dm_be = 0001 << addr[1:0].
  - half: Dm_wdata = {2{busB[15:0]}}, Dm_be = addr[1] ? 1100 : 0011.
  - word: Dm_wdata = busB, Dm_be = 1111.
- Loads: Dm_be = 1111. Extract the byte/half selected by addr[1:0], then sign- or zero-extend to 32 bits per Mem_MemSign.
- Dm_ack while in IDLE or DONE: ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]≠00 is misaligned.
  - Mem_AddrErr=1 combinationally while such an instruction sits in MEM.
  - No bus transaction, Mem_Stall=0, Mem_dout unchanged, FSM stays IDLE.
- Undefined: Mem_AddrErr tied 0. Half accesses ignore addr[0] and word accesses ignore addr[1:0]; the access proceeds normally.

Test Plan:
- Load byte signed: addr 0x00000103, rdata 0x80FF1234, ack one cycle after req → Mem_dout=0xFFFFFF80. Mem_Stall high exactly 2 cycles, Dm_be=1111.
- Store half: addr 0x00000042, busB 0x0000BEEF → Dm_addr=0x10, Dm_be=1100, Dm_wdata=0xBEEFBEEF, Dm_we=1. Mem_dout unchanged.
- Load half unsigned, ack delayed 5 cycles: addr 0x8, rdata 0x1234ABCD → Mem_dout=0x0000ABCD. Stall lasts 6 cycles, Dm_* stable throughout WAIT.
- Timeout with TIMEOUT_CYCLES=4, no ack → Dm_req drops after 4 WAIT cycles, Mem_BusErr one-cycle pulse, Mem_dout=0, then back to IDLE.
- Rst_n asserted low in mid-WAIT → Dm_req=0 and Mem_Stall=0 immediately. After release, a new load completes normally.
- Word load at addr 0x6: with MISALIGN_TRAP_EN, Mem_AddrErr=1, no Dm_req, no stall. Without it, Dm_addr=0x1 and the access completes.
